// File: rtl/cacheline_adapter.sv
// Cacheline-to-burst adapter: one 256-bit line request becomes four 64-bit beats, low word first.
// Optional watchdog guarded by CACHELINE_ADAPTER_TIMEOUT_EN.
module cacheline_adapter #(
   parameter int unsigned LINE_W         = 256,
   parameter int unsigned BEAT_W         = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       line_address,
   input  logic [LINE_W-1:0] line_wdata,
   input  logic              line_read,
   input  logic              line_write,
   output logic [LINE_W-1:0] line_rdata,
   output logic              line_resp,
   output logic [31:0]       burst_address,
   output logic [BEAT_W-1:0] burst_wdata,
   output logic              burst_read,
   output logic              burst_write,
   input  logic [BEAT_W-1:0] burst_rdata,
   input  logic              burst_resp,
   output logic              timeout_err
);

   localparam int unsigned      BEATS     = LINE_W / BEAT_W;
   localparam int unsigned      CNT_W     = $clog2(BEATS);
   localparam logic [31:0]      ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [LINE_W-1:0] wline;
   logic              beat;
   logic              start;
   logic              wd_expire;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next  = state;
      burst_read  = 1'b0;
      burst_write = 1'b0;
      line_resp   = 1'b0;
      beat        = 1'b0;
      start       = 1'b0;
      unique case (state)
         IDLE: begin
            start = line_write | line_read;
            if (line_write)     state_next = WRITE;
            else if (line_read) state_next = READ;
         end
         READ: begin
            burst_read = 1'b1;
            beat       = burst_resp;
            if ((burst_resp && cnt == LAST) || wd_expire) state_next = RESP;
         end
         WRITE: begin
            burst_write = 1'b1;
            beat        = burst_resp;
            if ((burst_resp && cnt == LAST) || wd_expire) state_next = RESP;
         end
         RESP: begin
            line_resp  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Write beat is a slice of the latched line, so no line_* input reaches the burst side combinationally.
   assign burst_wdata = wline[32'(cnt) * BEAT_W +: BEAT_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         burst_address <= '0;
         wline         <= '0;
         line_rdata    <= '0;
      end else if (start) begin
         cnt           <= '0;
         burst_address <= line_address & ADDR_MASK;
         if (line_write) wline <= line_wdata;
      end else if (beat) begin
         cnt <= cnt + 1'b1;
         if (state == READ) line_rdata[32'(cnt) * BEAT_W +: BEAT_W] <= burst_rdata;
      end
   end

`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_err;

   // Fires in the last silent cycle so the flag and RESP appear together TIMEOUT_CYCLES+1 cycles after the strobe.
   assign wd_expire = (state == READ || state == WRITE) && !burst_resp &&
                      (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         wd_err <= 1'b0;
      end else begin
         if (state == IDLE || state == RESP || burst_resp) wd_cnt <= '0;
         else                                              wd_cnt <= wd_cnt + 1'b1;
         if (wd_expire) wd_err <= 1'b1;
      end
   end

   assign timeout_err = wd_err;
`else
   assign wd_expire   = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: read, gapped write, request priority, mid-transfer reset, stray beats.
module tb_cacheline_adapter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  line_address;
   logic [255:0] line_wdata;
   logic         line_read;
   logic         line_write;
   logic [255:0] line_rdata;
   logic         line_resp;
   logic [31:0]  burst_address;
   logic [63:0]  burst_wdata;
   logic         burst_read;
   logic         burst_write;
   logic [63:0]  burst_rdata;
   logic         burst_resp;
   logic         timeout_err;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   cacheline_adapter #(
      .LINE_W        (256),
      .BEAT_W        (64),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .line_address (line_address),
      .line_wdata   (line_wdata),
      .line_read    (line_read),
      .line_write   (line_write),
      .line_rdata   (line_rdata),
      .line_resp    (line_resp),
      .burst_address(burst_address),
      .burst_wdata  (burst_wdata),
      .burst_read   (burst_read),
      .burst_write  (burst_write),
      .burst_rdata  (burst_rdata),
      .burst_resp   (burst_resp),
      .timeout_err  (timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [255:0] rd_line;
   logic [255:0] wr_line;
   logic [63:0]  exp_w;
   int unsigned  wcycles;

   initial begin
      rst = 1'b1; line_address = '0; line_wdata = '0; line_read = 1'b0; line_write = 1'b0;
      burst_rdata = '0; burst_resp = 1'b0;
      tick(); tick();
      chk("rst_rdata", line_rdata, '0);
      chk("rst_resp", line_resp, 0);
      chk("rst_bread", burst_read, 0);
      chk("rst_bwrite", burst_write, 0);
      chk("rst_baddr", burst_address, 0);
      chk("rst_bwdata", burst_wdata, 0);
      chk("rst_tmo", timeout_err, 0);
      rst = 1'b0;
      tick();

      // stray beats in IDLE
      burst_resp = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         chk("stray_bread", burst_read, 0);
         chk("stray_bwrite", burst_write, 0);
         chk("stray_resp", line_resp, 0);
      end
      burst_resp = 1'b0;
      tick();

      // read, back-to-back beats
      rd_line = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
      line_address = 32'h0000_1234; line_read = 1'b1;
      tick();
      line_address = 32'hFFFF_FFFF;
      for (int unsigned k = 0; k < 4; k++) begin
         chk("rd_bread", burst_read, 1);
         chk("rd_baddr", burst_address, 32'h0000_1220);
         chk("rd_resp_early", line_resp, 0);
         burst_resp = 1'b1; burst_rdata = rd_line[k*64 +: 64];
         tick();
      end
      burst_resp = 1'b0; burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      chk("rd_resp_t5", line_resp, 1);
      chk("rd_bread_off", burst_read, 0);
      chk("rd_line", line_rdata, rd_line);
      tick();
      chk("rd_resp_once", line_resp, 0);
      line_read = 1'b0;
      tick();
      chk("rd_no_retrigger", burst_read, 0);

      // write with gaps: one idle cycle before the first beat, two between the rest
      for (int unsigned i = 0; i < 8; i++) wr_line[i*32 +: 32] = 32'(i);
      line_address = 32'h0000_ABCD; line_wdata = wr_line; line_write = 1'b1;
      tick();
      line_address = 32'h1234_5678; line_wdata = '1;
      wcycles = 0;
      for (int unsigned k = 0; k < 4; k++) begin
         exp_w = {32'(2*k + 1), 32'(2*k)};
         for (int unsigned g = 0; g < ((k == 0) ? 2 : 3); g++) begin
            if (burst_write) wcycles++;
            chk("wr_bwdata", burst_wdata, exp_w);
            chk("wr_resp_early", line_resp, 0);
            burst_resp = (g == ((k == 0) ? 1 : 2));
            tick();
         end
      end
      burst_resp = 1'b0;
      chk("wr_hold_cycles", wcycles, 11);
      chk("wr_baddr_last", burst_address, 32'h0000_ABC0);
      chk("wr_resp", line_resp, 1);
      chk("wr_bwrite_off", burst_write, 0);
      chk("wr_rdata_kept", line_rdata, rd_line);
      tick();
      chk("wr_resp_once", line_resp, 0);
      line_write = 1'b0;
      tick();
      chk("wr_idle", burst_write, 0);
      chk("wr_idle_resp", line_resp, 0);

      // both requests high: write wins
      line_address = 32'h0000_2000; line_wdata = {4{64'h0123_4567_89AB_CDEF}};
      line_read = 1'b1; line_write = 1'b1;
      tick();
      chk("both_bwrite", burst_write, 1);
      chk("both_bread", burst_read, 0);
      burst_resp = 1'b1; burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick(); tick(); tick(); tick();
      burst_resp = 1'b0;
      chk("both_resp", line_resp, 1);
      chk("both_rdata_kept", line_rdata, rd_line);
      tick();
      line_read = 1'b0; line_write = 1'b0;
      tick();

      // reset after beat 1 of a read, then a fresh read
      line_address = 32'h0000_3000; line_read = 1'b1;
      tick();
      burst_resp = 1'b1; burst_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
      tick();
      burst_rdata = 64'hBBBB_BBBB_BBBB_BBBB;
      tick();
      burst_resp = 1'b0; rst = 1'b1;
      tick();
      chk("mrst_bread", burst_read, 0);
      chk("mrst_bwrite", burst_write, 0);
      chk("mrst_rdata", line_rdata, '0);
      chk("mrst_resp", line_resp, 0);
      rst = 1'b0; line_address = 32'h0000_4040;
      tick();
      rd_line = {64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555};
      chk("fresh_baddr", burst_address, 32'h0000_4040);
      for (int unsigned k = 0; k < 4; k++) begin
         chk("fresh_bread", burst_read, 1);
         burst_resp = 1'b1; burst_rdata = rd_line[k*64 +: 64];
         tick();
      end
      burst_resp = 1'b0;
      chk("fresh_resp", line_resp, 1);
      chk("fresh_line", line_rdata, rd_line);
      tick();
      line_read = 1'b0;
      tick();

`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
      // read with no beats; watchdog at 16
      line_address = 32'h0000_5000; line_read = 1'b1;
      tick();
      for (int unsigned c = 1; c <= 16; c++) begin
         chk("tmo_bread", burst_read, 1);
         chk("tmo_early", timeout_err, 0);
         tick();
      end
      chk("tmo_rise", timeout_err, 1);
      chk("tmo_resp", line_resp, 1);
      tick();
      line_read = 1'b0;
      chk("tmo_resp_once", line_resp, 0);
      tick(); tick();
      chk("tmo_sticky", timeout_err, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("tmo_clear", timeout_err, 0);
`else
      chk("tmo_tied", timeout_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
